ffvariant_checker: RTL and testbench
====================================

# ffvariant_checker

Synthesizable response checker for the flip-flop variant set (dff, dffe, dffer, dffess, dffnes). It observes the same stimulus that drives the five variants and their five `q` outputs. It runs a golden model of each variant and compares the model against the design under test every cycle. It keeps per-variant sticky flags and saturating error counts. It sits beside the variants in the FPGA architecture examples, so a self-checking flow needs no waveform inspection.

## Interface
Parameters:
- `WARMUP`, default 2: cycles spent in ARMED before checking starts.
- `ERR_W`, default 8: width of each per-variant error counter; counters saturate.
- `CNT_W`, default 16: width of the checked-cycle counter; the counter saturates.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `run`, in, 1: level signal; 1 starts or continues checking, 0 returns the block to IDLE.
- `d`, `en`, `set`, `dut_rst`, in, 1 each: stimulus copies, i.e. the same nets that drive the variants.
- `q_dff`, `q_dffe`, `q_dffer`, `q_dffess`, `q_dffnes`, in, 1 each: outputs of the design under test.
- `state`, out, 2: FSM state (IDLE=0, ARMED=1, CHECK=2, HALT=3).
- `mismatch`, out, 5: per-cycle mismatch pulse per variant. Bit order: 0=dff, 1=dffe, 2=dffer, 3=dffess, 4=dffnes.
- `err_sticky`, out, 5: sticky mismatch flags, same bit order.
- `err_cnt`, out, 5*ERR_W: packed error counts; variant i occupies bits [i*ERR_W +: ERR_W].
- `chk_cnt`, out, CNT_W: number of cycles compared while in CHECK.

## Operation
- Golden model semantics, all rising-edge:
  - dff: `q<=d`.
  - dffe: `if(en) q<=d`.
  - dffer: `if(dut_rst) q<=0; else if(en) q<=d`. Reset overrides enable.
  - dffess: `if(set) q<=1; else if(en) q<=d`. Set overrides enable.
  - dffnes: `if(en) q<= set ? 1 : d`. Set is gated by enable.
- Each model carries a valid bit.
  - Cleared by `rst`.
  - Set on the first edge where the model loads a value: dff always; dffe when `en`; dffer when `dut_rst|en`; dffess when `set|en`; dffnes when `en`.
  - Variant i is compared only when its valid bit is 1, so unknown power-up values are never flagged.
- Models and valid bits update in every state, including IDLE and HALT. The checker therefore tracks the design under test regardless of when `run` rises.
- FSM transitions:
  - IDLE→ARMED on `run=1`; the warmup counter loads WARMUP.
  - ARMED→CHECK when the warmup counter reaches 0. ARMED→IDLE if `run=0`.
  - CHECK→IDLE if `run=0`. CHECK→HALT as defined under Configuration.
  - HALT→IDLE on `run=0`.
- In CHECK, each edge performs the following:
  - `mismatch[i] <= valid[i] & (model_q[i] != q_i)`.
  - Sticky flags OR in the mismatch.
  - `err_cnt[i]` increments on mismatch and saturates at all-ones.
  - `chk_cnt` increments and saturates.
- Counters and sticky flags clear on the IDLE→ARMED transition. They hold in IDLE, ARMED and HALT.
- `mismatch` is 0 outside CHECK.

## Timing
- Reset values: `state`=IDLE, `mismatch`=0, `err_sticky`=0, `err_cnt`=0, `chk_cnt`=0, all valid bits 0, model q=0.
- The compare at edge n+1 uses the model value updated at edge n and the DUT `q` sampled at edge n+1. The DUT output settled after edge n is therefore judged at edge n+1.
- Latency: `mismatch` and counters are registered, so a wrong DUT `q` during cycle n is visible on `mismatch` during cycle n+1.
- `run` rising at edge k gives ARMED at k+1 and CHECK after WARMUP further edges. With WARMUP=0, CHECK is entered at edge k+2.
- Simultaneous events follow the model equations above: `dut_rst` together with `en` gives 0; `set` together with `en` gives 1 for both dffess and dffnes.
- Asserting `rst` mid-CHECK immediately forces all reset values.

## Configuration
- `FFCHK_STOP_ON_ERR_EN` defined:
  - CHECK→HALT on the edge where any `mismatch` bit is set. That edge's counts and flags are recorded.
  - HALT freezes the counters.
- `FFCHK_STOP_ON_ERR_EN` undefined:
  - HALT is unreachable and checking runs until `run=0`.
  - `state` never reads 3.

## Structure
- Shared package `ffchk_pkg`:
  - state encoding constants (IDLE, ARMED, CHECK, HALT);
  - variant index constants (V_DFF=0 … V_DFFNES=4);
  - `NVAR=5`.
- Sub-module `ffchk_lane`, instantiated five times with a variant-select parameter. Each lane holds the golden model, valid bit, compare, sticky flag and saturating error counter.
- The top level owns the FSM, warmup counter and `chk_cnt`.

## Test plan
- Reset then `run=1`, WARMUP=2, with fault-free variants driven by toggling d and en → state 0→1→1→2; `mismatch`=0 throughout; `err_cnt`=0; `chk_cnt` counts CHECK cycles.
- Force `q_dffe` to hold while `en=1`, `d`=1, model=0 → `mismatch[1]` pulses the following cycle, `err_sticky`=5'b00010, `err_cnt[1]`=1.
- `set=1`, `en=0` → dffess model goes to 1 and dffnes model holds. Feeding swapped `q`s sets `err_sticky`=5'b11000.
- Hold the stuck fault for 300 cycles with ERR_W=8 → `err_cnt` for that variant saturates at 255 and does not wrap.
- With `FFCHK_STOP_ON_ERR_EN`, inject a single mismatch → state=3 on the next edge, and `chk_cnt` and `err_cnt` are frozen. `run=0` → state=0. Without the macro, state stays 2.
- Assert `rst` mid-CHECK with nonzero counts → all outputs and valid bits 0 immediately; the first post-reset cycles raise no `mismatch` before the valid bits set.

Source files
------------

// File: rtl/ffchk_pkg.sv
// Shared definitions for the flip-flop variant response checker.
package ffchk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CHECK = 2'd2, HALT = 2'd3} state_t;
  localparam int NVAR      = 5;
  localparam int V_DFF     = 0;
  localparam int V_DFFE    = 1;
  localparam int V_DFFER   = 2;
  localparam int V_DFFESS  = 3;
  localparam int V_DFFNES  = 4;
endpackage

// File: rtl/ffchk_lane.sv
// One checker lane: golden model of a single variant, valid bit, compare,
// sticky flag and saturating error counter.
module ffchk_lane
  import ffchk_pkg::*;
#(
  parameter int VSEL  = V_DFF,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             set,
  input  logic             dut_rst,
  input  logic             q,
  input  logic             chk,
  input  logic             clr,
  output logic             mis_now,
  output logic             mis,
  output logic             sticky,
  output logic [ERR_W-1:0] cnt
);
  logic mq, vld, ld, nq;

  always_comb begin
    ld = 1'b0;
    nq = mq;
    case (VSEL)
      V_DFF:    begin ld = 1'b1;          nq = d;                               end
      V_DFFE:   begin ld = en;            nq = d;                               end
      V_DFFER:  begin ld = dut_rst | en;  nq = dut_rst ? 1'b0 : d;              end
      V_DFFESS: begin ld = set | en;      nq = set ? 1'b1 : d;                  end
      V_DFFNES: begin ld = en;            nq = set ? 1'b1 : d;                  end
      default:  begin ld = 1'b0;          nq = mq;                              end
    endcase
  end

  // model is only trusted once it has loaded a value since reset
  assign mis_now = vld & (mq != q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mq     <= 1'b0;
      vld    <= 1'b0;
      mis    <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      if (ld) begin
        mq  <= nq;
        vld <= 1'b1;
      end
      mis <= chk & mis_now;
      if (clr) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end else if (chk && mis_now) begin
        sticky <= 1'b1;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ffvariant_checker.sv
// Response checker for dff/dffe/dffer/dffess/dffnes: FSM, warmup and checked-cycle count.
// Optional FFCHK_STOP_ON_ERR_EN: halt checking on the first mismatch.
module ffvariant_checker
  import ffchk_pkg::*;
#(
  parameter int WARMUP = 2,
  parameter int ERR_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  d,
  input  logic                  en,
  input  logic                  set,
  input  logic                  dut_rst,
  input  logic                  q_dff,
  input  logic                  q_dffe,
  input  logic                  q_dffer,
  input  logic                  q_dffess,
  input  logic                  q_dffnes,
  output logic [1:0]            state,
  output logic [NVAR-1:0]       mismatch,
  output logic [NVAR-1:0]       err_sticky,
  output logic [NVAR*ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0]      chk_cnt
);
`ifdef FFCHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif
  localparam int WW = $clog2(WARMUP + 2);

  state_t          st, nxt;
  logic [WW-1:0]   wcnt;
  logic            chk, clr;
  logic [NVAR-1:0] qv, mis_now;

  assign qv = {q_dffnes, q_dffess, q_dffer, q_dffe, q_dff};

  for (genvar g = 0; g < NVAR; g++) begin : g_lane
    ffchk_lane #(.VSEL(g), .ERR_W(ERR_W)) u_lane (
      .clk(clk), .rst(rst), .d(d), .en(en), .set(set), .dut_rst(dut_rst),
      .q(qv[g]), .chk(chk), .clr(clr),
      .mis_now(mis_now[g]), .mis(mismatch[g]), .sticky(err_sticky[g]),
      .cnt(err_cnt[g*ERR_W +: ERR_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  // ARMED lasts max(1, WARMUP) cycles
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (run) nxt = ARMED;
      ARMED:   if (!run) nxt = IDLE; else if (wcnt <= WW'(1)) nxt = CHECK;
      CHECK:   if (!run) nxt = IDLE; else if (STOP_ON_ERR && (|mis_now)) nxt = HALT;
      HALT:    if (!run) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    state = st;
    chk   = (st == CHECK);
    clr   = (st == IDLE) & run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      chk_cnt <= '0;
    end else begin
      if (clr)                           wcnt <= WW'(WARMUP);
      else if (st == ARMED && wcnt != 0) wcnt <= wcnt - 1'b1;
      if (clr)                           chk_cnt <= '0;
      else if (chk && chk_cnt != '1)     chk_cnt <= chk_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ffvariant_checker.sv
// Directed bench for ffvariant_checker with a behavioural scoreboard model.
module tb_ffvariant_checker;
  localparam int WARMUP = 2;
  localparam int ERR_W  = 8;
  localparam int CNT_W  = 16;
  localparam int ARMLEN = (WARMUP == 0) ? 1 : WARMUP;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic d = 1'b0, en = 1'b0, set = 1'b0, dut_rst = 1'b0;
  logic [4:0] ovr = '0, oval = '0;
  logic swp = 1'b0, go = 1'b0;
  logic [1:0] state;
  logic [4:0] mismatch, err_sticky;
  logic [5*ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;

  int ncmp = 0, nerr = 0;

  // ideal variant outputs (fault-free design) and what the checker should report
  logic [4:0] iq, ivld, qv, qin, m_now, ld_vec, nq;
  logic [1:0] est;
  int acyc;
  logic [4:0] emis, estk;
  logic [4:0][7:0] eerr;
  logic [CNT_W-1:0] echk;

  always #5 clk = ~clk;

  assign qv     = swp ? {iq[3], iq[4], iq[2:0]} : iq;
  assign qin    = (qv & ~ovr) | (oval & ovr);
  assign m_now  = ivld & (qin ^ iq);
  assign ld_vec = {en, set | en, dut_rst | en, en, 1'b1};
  assign nq     = {en ? (set | d) : iq[4],
                   set ? 1'b1 : (en ? d : iq[3]),
                   dut_rst ? 1'b0 : (en ? d : iq[2]),
                   en ? d : iq[1],
                   d};

  ffvariant_checker #(.WARMUP(WARMUP), .ERR_W(ERR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .d(d), .en(en), .set(set), .dut_rst(dut_rst),
    .q_dff(qin[0]), .q_dffe(qin[1]), .q_dffer(qin[2]), .q_dffess(qin[3]), .q_dffnes(qin[4]),
    .state(state), .mismatch(mismatch), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      iq <= '0; ivld <= '0; est <= 2'd0; acyc <= 0;
      emis <= '0; estk <= '0; eerr <= '0; echk <= '0;
    end else begin
      iq   <= nq;
      ivld <= ivld | ld_vec;
      emis <= (est == 2'd2) ? m_now : 5'b0;
      case (est)
        2'd0: if (run) begin est <= 2'd1; acyc <= 1; estk <= '0; eerr <= '0; echk <= '0; end
        2'd1: if (!run) est <= 2'd0; else if (acyc >= ARMLEN) est <= 2'd2; else acyc <= acyc + 1;
        2'd2: begin
          estk <= estk | m_now;
          for (int i = 0; i < 5; i++)
            if (m_now[i] && eerr[i] != 8'hFF) eerr[i] <= eerr[i] + 8'd1;
          if (echk != {CNT_W{1'b1}}) echk <= echk + 1'b1;
          if (!run) est <= 2'd0;
`ifdef FFCHK_STOP_ON_ERR_EN
          else if (|m_now) est <= 2'd3;
`endif
        end
        default: if (!run) est <= 2'd0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go && !rst) begin
      chk("state", 64'(state), 64'(est));
      chk("mismatch", 64'(mismatch), 64'(emis));
      chk("err_sticky", 64'(err_sticky), 64'(estk));
      chk("err_cnt", 64'(err_cnt), 64'(eerr));
      chk("chk_cnt", 64'(chk_cnt), 64'(echk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs", 64'({mismatch, err_sticky, err_cnt, chk_cnt}), 64'd0);
    rst = 1'b0; go = 1'b1;
    en = 1'b1; d = 1'b1; cyc(1);
    d = 1'b0; set = 1'b1; cyc(1);
    set = 1'b0; run = 1'b1; d = 1'b1;
    cyc(1); chk("arm0", 64'(state), 64'd1);
    d = 1'b0;
    cyc(1); chk("arm1", 64'(state), 64'd1);
    en = 1'b0; d = 1'b1;
    cyc(1); chk("check_entry", 64'(state), 64'd2);
    chk("chk_cnt_entry", 64'(chk_cnt), 64'd0);

    for (int i = 0; i < 12; i++) begin
      d = i[0]; en = (i % 3) != 0; set = (i % 5) == 4; dut_rst = (i % 7) == 6;
      cyc(1);
    end
    chk("chk_cnt_12", 64'(chk_cnt), 64'd12);
    chk("err_cnt_clean", 64'(err_cnt), 64'd0);

    // dffe stuck low while en loads a 1
    d = 1'b0; en = 1'b1; set = 1'b0; dut_rst = 1'b0; cyc(1);
    ovr = 5'b00010; oval = 5'b00000; d = 1'b1; cyc(2);
    chk("dffe_mis", 64'(mismatch), 64'b00010);
    chk("dffe_sticky", 64'(err_sticky), 64'b00010);
    chk("dffe_cnt", 64'(err_cnt[15:8]), 64'd1);
    ovr = '0; en = 1'b0;
`ifdef FFCHK_STOP_ON_ERR_EN
    chk("halt_state", 64'(state), 64'd3);
    cyc(2);
    chk("halt_chk_frozen", 64'(chk_cnt), 64'd15);
    chk("halt_err_frozen", 64'(err_cnt[15:8]), 64'd1);
`else
    chk("no_halt_state", 64'(state), 64'd2);
    cyc(1);
    chk("dffe_mis_clear", 64'(mismatch), 64'd0);
`endif
    run = 1'b0; cyc(1);
    chk("idle_again", 64'(state), 64'd0);

    // set without enable: dffess takes 1, dffnes holds; feed them swapped
    run = 1'b1; en = 1'b1; d = 1'b0; cyc(3);
    chk("restart_check", 64'(state), 64'd2);
    chk("restart_sticky", 64'(err_sticky), 64'd0);
    set = 1'b1; en = 1'b0; swp = 1'b1; cyc(2);
    chk("swap_sticky", 64'(err_sticky), 64'b11000);
    chk("swap_cnt", 64'(err_cnt[39:24]), 64'h0101);
    swp = 1'b0; set = 1'b0;

`ifndef FFCHK_STOP_ON_ERR_EN
    // dff stuck at 0 while d=1: counter must saturate at 255
    run = 1'b0; cyc(1);
    run = 1'b1; d = 1'b1; en = 1'b1; ovr = 5'b00001; oval = 5'b00000; cyc(3);
    chk("sat_entry", 64'(state), 64'd2);
    cyc(300);
    chk("sat_cnt", 64'(err_cnt[7:0]), 64'd255);
    chk("sat_sticky", 64'(err_sticky), 64'b00001);
    chk("sat_chk_cnt", 64'(chk_cnt), 64'd300);
`endif

    // asynchronous reset mid-run
    rst = 1'b1; #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_outs", 64'({mismatch, err_sticky, err_cnt, chk_cnt}), 64'd0);
    cyc(1);
    d = 1'b0; en = 1'b0; set = 1'b0; dut_rst = 1'b0;
    ovr = 5'b11110; oval = 5'b11110; run = 1'b1; rst = 1'b0;
    cyc(8);
    chk("post_rst_state", 64'(state), 64'd2);
    chk("post_rst_sticky", 64'(err_sticky), 64'd0);
    chk("post_rst_chk", 64'(chk_cnt), 64'd5);
    go = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
